edge_event_arbiter: RTL and testbench

//  Multi-channel trigger scheduler for the Ethernet event path.
//  - Detects rising edges on NCH trigger inputs and timestamps each edge from a free-running counter.
//  - Holds one pending event per channel.
//  - Grants pending events one at a time, round-robin, to the shared frame builder over a req/ack handshake.
//  - Enforces a minimum gap between grants.

---
 rtl/eth_arb_pkg.sv | 26 ++
 rtl/edge_event_arbiter_rr_pick.sv | 41 ++++
 rtl/edge_event_arbiter.sv | 177 +++++++++++++++++
 tb/tb_edge_event_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_arb_pkg.sv
// Shared definitions for the edge event arbiter.
//   state_t : arbiter FSM states (IDLE / REQ / HOLD)
//   clog2   : ceiling log2 with a floor of 1, used for index/counter widths
package eth_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/edge_event_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority selector.
//   pend  : request vector, one bit per channel
//   last  : most recently granted channel
//   valid : at least one request present
//   idx   : first requesting channel searching upward from last+1, wrapping
module rr_pick
    import eth_arb_pkg::*;
#(
    parameter int unsigned NCH = 4,
    localparam int unsigned CW = clog2(NCH)
) (
    input  logic [NCH-1:0] pend,
    input  logic [CW-1:0]  last,
    output logic           valid,
    output logic [CW-1:0]  idx
);

    int unsigned   cand;
    logic [CW-1:0] c;

    // Walk offsets from farthest to nearest so the nearest hit after
    // last is the one left standing.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        c     = '0;
        for (int unsigned off = NCH; off >= 1; off--) begin
            cand = 32'(last) + off;
            if (cand >= NCH) begin
                cand = cand - NCH;
            end
            c = CW'(cand);
            if (pend[c]) begin
                valid = 1'b1;
                idx   = c;
            end
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: multi-channel trigger scheduler.
// Detects rising trigger edges, timestamps them from a free-running counter,
// holds one pending event per channel and grants them round-robin over a
// req/ack handshake with a HOLDOFF-cycle gap after every ack.
//   clk, rst   : clock, synchronous active-high reset
//   i_trig     : trigger levels (synchronous to clk)
//   i_enable   : per-channel enable mask
//   i_ack      : consumer accepted the current grant
//   i_clr_ovr  : clear all overrun flags
//   o_req      : grant valid
//   o_ch, o_ts : granted channel and its captured timestamp
//   o_overrun  : sticky per-channel lost-edge flags
//   o_busy     : FSM active or any event pending
module edge_event_arbiter
    import eth_arb_pkg::*;
#(
    parameter int unsigned NCH     = 4,
    parameter int unsigned TS_W    = 32,
    parameter int unsigned HOLDOFF = 16,
    localparam int unsigned CW     = clog2(NCH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH-1:0]  i_trig,
    input  logic [NCH-1:0]  i_enable,
    input  logic            i_ack,
    input  logic            i_clr_ovr,
    output logic            o_req,
    output logic [CW-1:0]   o_ch,
    output logic [TS_W-1:0] o_ts,
    output logic [NCH-1:0]  o_overrun,
    output logic            o_busy
);

    localparam int unsigned HW = clog2(HOLDOFF + 1);

    state_t          state_q, state_d;
    logic [NCH-1:0]  prev_q;
    logic [NCH-1:0]  pend_q, pend_d;
    logic [TS_W-1:0] ts_q [NCH];
    logic [TS_W-1:0] ts_d [NCH];
    logic [TS_W-1:0] cnt_ts_q;
    logic [HW-1:0]   hold_q, hold_d;
    logic [CW-1:0]   last_q, last_d;
    logic            req_q, req_d;
    logic [CW-1:0]   ch_q, ch_d;
    logic [TS_W-1:0] tsout_q, tsout_d;
    logic [NCH-1:0]  ovr_q, ovr_d;
    logic            busy_q, busy_d;

    logic [NCH-1:0]  cap;
    logic [NCH-1:0]  new_ovr;
    logic            ack_fire;
    logic            pick_valid;
    logic [CW-1:0]   pick_idx;

    // Disabled channels are masked from selection so a pending event whose
    // enable drops is discarded rather than granted on the same edge.
    rr_pick #(.NCH(NCH)) u_pick (
        .pend  (pend_q & i_enable),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        cap      = i_trig & ~prev_q & i_enable;
        ack_fire = (state_q == ST_REQ) && i_ack;
        pend_d   = pend_q;
        ts_d     = ts_q;
        new_ovr  = '0;

        // The channel held in REQ keeps its pending bit even when disabled;
        // an edge landing on its ack cycle re-arms it instead of overrunning.
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!i_enable[i] && !((state_q == ST_REQ) && (ch_q == CW'(i)))) begin
                pend_d[i] = 1'b0;
            end else if (ack_fire && (ch_q == CW'(i))) begin
                pend_d[i] = cap[i];
                if (cap[i]) begin
                    ts_d[i] = cnt_ts_q;
                end
            end else if (cap[i]) begin
                if (!pend_q[i]) begin
                    pend_d[i] = 1'b1;
                    ts_d[i]   = cnt_ts_q;
                end else begin
                    new_ovr[i] = 1'b1;
                end
            end
        end

        ovr_d = (i_clr_ovr ? '0 : ovr_q) | new_ovr;

        state_d = state_q;
        hold_d  = hold_q;
        last_d  = last_q;
        req_d   = req_q;
        ch_d    = ch_q;
        tsout_d = tsout_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    req_d   = 1'b1;
                    ch_d    = pick_idx;
                    tsout_d = ts_q[pick_idx];
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_ack) begin
                    req_d  = 1'b0;
                    last_d = ch_q;
                    if (HOLDOFF == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLD;
                        hold_d  = HW'(HOLDOFF - 1);
                    end
                end
            end
            ST_HOLD: begin
                if (hold_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE) || (|pend_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            prev_q   <= '0;
            pend_q   <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                ts_q[i] <= '0;
            end
            cnt_ts_q <= '0;
            hold_q   <= '0;
            last_q   <= CW'(NCH - 1);
            req_q    <= 1'b0;
            ch_q     <= '0;
            tsout_q  <= '0;
            ovr_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= i_trig;
            pend_q   <= pend_d;
            ts_q     <= ts_d;
            cnt_ts_q <= cnt_ts_q + TS_W'(1);
            hold_q   <= hold_d;
            last_q   <= last_d;
            req_q    <= req_d;
            ch_q     <= ch_d;
            tsout_q  <= tsout_d;
            ovr_q    <= ovr_d;
            busy_q   <= busy_d;
        end
    end

    assign o_req     = req_q;
    assign o_ch      = ch_q;
    assign o_ts      = tsout_q;
    assign o_overrun = ovr_q;
    assign o_busy    = busy_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench for edge_event_arbiter: two instances (HOLDOFF=16 and
// HOLDOFF=0) share trigger/enable/clear/reset stimulus with separate acks,
// and both are compared every cycle against a behavioural event model.
module tb_edge_event_arbiter;

    localparam int NCH  = 4;
    localparam int TS_W = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NCH-1:0]  trig = '0;
    logic [NCH-1:0]  en = '1;
    logic            ack_a = 1'b0;
    logic            ack_b = 1'b0;
    logic            clr = 1'b0;

    logic            req_a, req_b, busy_a, busy_b;
    logic [1:0]      ch_a, ch_b;
    logic [TS_W-1:0] ts_a, ts_b;
    logic [NCH-1:0]  ovr_a, ovr_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    edge_event_arbiter #(.NCH(NCH), .TS_W(TS_W), .HOLDOFF(16)) dut_a (
        .clk(clk), .rst(rst), .i_trig(trig), .i_enable(en), .i_ack(ack_a),
        .i_clr_ovr(clr), .o_req(req_a), .o_ch(ch_a), .o_ts(ts_a),
        .o_overrun(ovr_a), .o_busy(busy_a)
    );

    edge_event_arbiter #(.NCH(NCH), .TS_W(TS_W), .HOLDOFF(0)) dut_b (
        .clk(clk), .rst(rst), .i_trig(trig), .i_enable(en), .i_ack(ack_b),
        .i_clr_ovr(clr), .o_req(req_b), .o_ch(ch_b), .o_ts(ts_b),
        .o_overrun(ovr_b), .o_busy(busy_b)
    );

    // Behavioural model state, index 0 = HOLDOFF 16 instance, 1 = HOLDOFF 0.
    int unsigned    gap_cfg [2] = '{16, 0};
    logic [NCH-1:0] m_prev [2];
    logic [NCH-1:0] m_pend [2];
    logic [NCH-1:0] m_ovr [2];
    int unsigned    m_stamp [2][NCH];
    logic           m_req [2];
    logic           m_busy [2];
    int unsigned    m_ch [2];
    int unsigned    m_ts [2];
    int unsigned    m_gap [2];
    int unsigned    m_last [2];
    int unsigned    m_ctr [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int m, input logic ackv);
        logic [NCH-1:0] rise, capv, npend, novr;
        int unsigned    nstamp [NCH];
        logic           held, found;
        int unsigned    c;
        if (rst) begin
            m_prev[m] = '0; m_pend[m] = '0; m_ovr[m] = '0;
            m_req[m] = 1'b0; m_busy[m] = 1'b0; m_ch[m] = 0; m_ts[m] = 0;
            m_gap[m] = 0; m_last[m] = NCH - 1; m_ctr[m] = 0;
            for (int i = 0; i < NCH; i++) m_stamp[m][i] = 0;
            return;
        end
        rise  = trig & ~m_prev[m];
        capv  = rise & en;
        npend = m_pend[m];
        novr  = '0;
        for (int i = 0; i < NCH; i++) nstamp[i] = m_stamp[m][i];
        for (int i = 0; i < NCH; i++) begin
            held = m_req[m] && (m_ch[m] == i);
            if (held && ackv) begin
                npend[i] = capv[i];
                if (capv[i]) nstamp[i] = m_ctr[m];
            end else if (!en[i] && !held) begin
                npend[i] = 1'b0;
            end else if (capv[i]) begin
                if (m_pend[m][i]) novr[i] = 1'b1;
                else begin
                    npend[i]  = 1'b1;
                    nstamp[i] = m_ctr[m];
                end
            end
        end
        if (m_req[m]) begin
            if (ackv) begin
                m_req[m]  = 1'b0;
                m_last[m] = m_ch[m];
                m_gap[m]  = gap_cfg[m];
            end
        end else if (m_gap[m] > 0) begin
            m_gap[m]--;
        end else begin
            found = 1'b0;
            for (int k = 1; k <= NCH; k++) begin
                c = (m_last[m] + k) % NCH;
                if (!found && m_pend[m][c] && en[c]) begin
                    found    = 1'b1;
                    m_req[m] = 1'b1;
                    m_ch[m]  = c;
                    m_ts[m]  = m_stamp[m][c];
                end
            end
        end
        m_pend[m] = npend;
        for (int i = 0; i < NCH; i++) m_stamp[m][i] = nstamp[i];
        m_ovr[m]  = (clr ? '0 : m_ovr[m]) | novr;
        m_prev[m] = trig;
        m_ctr[m]  = m_ctr[m] + 1;
        m_busy[m] = m_req[m] || (m_gap[m] > 0) || (|npend);
    endtask

    task automatic cmp(input int m, input logic rq, input logic [1:0] ch,
                       input logic [TS_W-1:0] ts, input logic [NCH-1:0] ov, input logic bz);
        chk($sformatf("m%0d_req", m),  rq, m_req[m]);
        chk($sformatf("m%0d_ch", m),   ch, m_ch[m]);
        chk($sformatf("m%0d_ts", m),   ts, m_ts[m]);
        chk($sformatf("m%0d_ovr", m),  ov, m_ovr[m]);
        chk($sformatf("m%0d_busy", m), bz, m_busy[m]);
    endtask

    task automatic step();
        @(posedge clk);
        model_step(0, ack_a);
        model_step(1, ack_b);
        #1;
        cmp(0, req_a, ch_a, ts_a, ovr_a, busy_a);
        cmp(1, req_b, ch_b, ts_b, ovr_b, busy_b);
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (req_a !== 1'b1 && n < 60) begin
            step();
            n++;
        end
        chk({tag, "_req_timeout"}, req_a, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy_a !== 1'b0 && n < 80) begin
            step();
            n++;
        end
        chk({tag, "_idle_timeout"}, busy_a, 1'b0);
    endtask

    task automatic ack_grant();
        ack_a = 1'b1;
        step();
        ack_a = 1'b0;
    endtask

    initial begin
        int unsigned t1, t2, tr;
        logic seen;

        // Reset state
        rst = 1'b1; ack_b = 1'b1;
        step(); step();
        chk("rst_req", req_a, 1'b0);
        chk("rst_ovr", ovr_a, '0);
        chk("rst_busy", busy_a, 1'b0);
        rst = 1'b0;

        // 1: single rise on ch2 sampled when the counter reads 5
        for (int i = 0; i < 5; i++) step();
        trig = 4'b0100;
        step();
        chk("t1_req_not_yet", req_a, 1'b0);
        step();
        chk("t1_req", req_a, 1'b1);
        chk("t1_ch", ch_a, 2);
        chk("t1_ts", ts_a, 5);
        for (int i = 0; i < 3; i++) step();
        chk("t1_req_held", req_a, 1'b1);
        chk("t1_ts_held", ts_a, 5);
        ack_grant();
        chk("t1_req_drop", req_a, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin step(); seen |= req_a; end
        chk("t1_gap_low", seen, 1'b0);
        trig = '0;

        // 2: simultaneous rises, rotation from ch0 after reset
        rst = 1'b1; step(); rst = 1'b0;
        tr = m_ctr[0];
        trig = 4'b1111;
        step();
        for (int g = 0; g < NCH; g++) begin
            wait_req($sformatf("t2_g%0d", g));
            chk($sformatf("t2_ch%0d", g), ch_a, g);
            chk($sformatf("t2_ts%0d", g), ts_a, tr);
            ack_grant();
        end
        trig = '0;
        step();
        trig = 4'b0011;
        step();
        for (int g = 0; g < 2; g++) begin
            wait_req($sformatf("t2b_g%0d", g));
            chk($sformatf("t2b_ch%0d", g), ch_a, g);
            ack_grant();
        end
        trig = '0;
        wait_idle("t2");

        // 3: overrun keeps the first stamp; clear removes the flag
        t1 = m_ctr[0];
        trig = 4'b0010;
        step();
        trig = '0;
        for (int i = 0; i < 6; i++) step();
        trig = 4'b0010;
        step();
        trig = '0;
        step();
        chk("t3_req", req_a, 1'b1);
        chk("t3_ts_first", ts_a, t1);
        chk("t3_ovr_set", ovr_a[1], 1'b1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("t3_ovr_clr", ovr_a, '0);
        ack_grant();
        wait_idle("t3");

        // 4: re-trigger on the ack cycle re-arms without overrun
        trig = 4'b1000;
        step();
        trig = '0;
        wait_req("t4_first");
        chk("t4_ch", ch_a, 3);
        step();
        t2 = m_ctr[0];
        trig = 4'b1000;
        ack_a = 1'b1;
        step();
        ack_a = 1'b0;
        trig = '0;
        chk("t4_no_ovr", ovr_a, '0);
        chk("t4_req_drop", req_a, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin step(); seen |= req_a; end
        chk("t4_gap_low", seen, 1'b0);
        step();
        chk("t4_regrant", req_a, 1'b1);
        chk("t4_ch3", ch_a, 3);
        chk("t4_new_ts", ts_a, t2);
        ack_grant();
        wait_idle("t4");

        // 5: dropping the enable of a pending, ungranted channel discards it
        trig = 4'b0101;
        step();
        step();
        chk("t5_grant_ch0", ch_a, 0);
        en = 4'b1011;
        step();
        en = 4'b1111;
        trig = '0;
        ack_grant();
        seen = 1'b0;
        for (int i = 0; i < 24; i++) begin step(); seen |= req_a; end
        chk("t5_no_grant", seen, 1'b0);
        chk("t5_idle", busy_a, 1'b0);

        // 5b: HOLDOFF=0 with continuous ack alternates req every cycle
        trig = 4'b1111;
        step();
        for (int g = 0; g < NCH; g++) begin
            step();
            chk($sformatf("t5b_req_hi%0d", g), req_b, 1'b1);
            step();
            chk($sformatf("t5b_req_lo%0d", g), req_b, 1'b0);
        end

        // 6: reset while a grant is outstanding and an overrun is flagged
        trig = '0;
        step();
        trig = 4'b0100;
        step();
        trig = '0;
        step();
        chk("t6_pre_req", req_a, 1'b1);
        chk("t6_pre_ovr", ovr_a[2], 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_req", req_a, 1'b0);
        chk("t6_ovr", ovr_a, '0);
        chk("t6_busy", busy_a, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin step(); seen |= req_a | busy_a; end
        chk("t6_stale_gone", seen, 1'b0);

        // Random phase
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 5) == 0) trig[i] = ~trig[i];
            end
            if ($urandom_range(0, 19) == 0) en = 4'($urandom);
            ack_a = ($urandom_range(0, 2) == 0);
            ack_b = ($urandom_range(0, 1) == 0);
            clr   = ($urandom_range(0, 24) == 0);
            rst   = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
